// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter plus a direct-mapped one-word-per-line
// instruction cache that refills from instruction memory over a req/ack handshake.
//
// state  | meaning
// RUN    | fetching; hits advance pc, misses start a refill
// REFILL | waiting for mem_ack; redirects are parked in the pending register
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          LINES    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic [31:0] instruction,
    output logic        hit
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - IW;

    typedef enum logic {
        RUN,
        REFILL
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       pc_nxt;
    logic              pend_valid;
    logic              pend_valid_nxt;
    logic [31:0]       pend_pc;
    logic [31:0]       pend_pc_nxt;
    logic [31:0]       target;
    logic              fill;

    logic [LINES-1:0]  line_valid;
    logic [TW-1:0]     line_tag  [LINES];
    logic [31:0]       line_data [LINES];

    logic [IW-1:0]     idx;
    logic [TW-1:0]     tag;

    assign idx         = pc[IW+1:2];
    assign tag         = pc[31:IW+2];
    assign target      = redirect_pc & 32'hFFFF_FFFC;
    assign fill        = (state == REFILL) && mem_ack;

    assign hit         = (state == RUN) && line_valid[idx] && (line_tag[idx] == tag);
    assign instruction = hit ? line_data[idx] : 32'h0000_0000;
    assign next_pc     = pc + 32'd4;
    assign mem_req     = (state == REFILL);
    assign mem_addr    = {pc[31:2], 2'b00};

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_valid_nxt = pend_valid;
        pend_pc_nxt    = pend_pc;
        case (state)
            RUN: begin
                if (redirect) begin
                    pc_nxt = target;
                end else if (stall) begin
                    if (!hit) state_nxt = REFILL;
                end else if (hit) begin
                    pc_nxt = next_pc;
                end else begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    state_nxt      = RUN;
                    pend_valid_nxt = 1'b0;
                    // a redirect arriving with the ack is newer than anything parked
                    if (redirect)        pc_nxt = target;
                    else if (pend_valid) pc_nxt = pend_pc;
                end else if (redirect) begin
                    pend_valid_nxt = 1'b1;
                    pend_pc_nxt    = target;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= 32'h0000_0000;
            line_valid <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pend_valid <= pend_valid_nxt;
            pend_pc    <= pend_pc_nxt;
            if (fill) line_valid[idx] <= 1'b1;
        end
    end

    // tag/data storage needs no reset; the valid bits gate every use
    always_ff @(posedge clk) begin
        if (rst_n && fill) begin
            line_tag[idx]  <= tag;
            line_data[idx] <= mem_rdata;
        end
    end

endmodule
